// File: rtl/reduce_egress.sv
// Egress stage behind the reduction table: buffers completed packets in a small FIFO
// and forwards them to the host (root node) or network port. Optional stats: REDUCE_EGRESS_STATS_EN.
module reduce_egress #(
  parameter int DataWidth     = 64,
  parameter int FifoDepth     = 4,
  parameter int FifoAddrWidth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [DataWidth-1:0]     in_packet,
  output logic [DataWidth-1:0]     net_data,
  output logic                     net_valid,
  input  logic                     net_ready,
  output logic [DataWidth-1:0]     host_data,
  output logic                     host_valid,
  input  logic                     host_ready,
  output logic                     overflow,
  output logic                     malformed,
  output logic [FifoAddrWidth:0]   fifo_count
`ifdef REDUCE_EGRESS_STATS_EN
  ,
  output logic [15:0]              net_sent_cnt,
  output logic [15:0]              host_sent_cnt,
  output logic [7:0]               drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_NET  = 2'd1,
    SEND_HOST = 2'd2
  } state_t;

  localparam logic [FifoAddrWidth:0]   DEPTH_C   = (FifoAddrWidth+1)'(FifoDepth);
  localparam logic [FifoAddrWidth:0]   CNT_ONE_C = (FifoAddrWidth+1)'(1);
  localparam logic [FifoAddrWidth-1:0] PTR_ONE_C = FifoAddrWidth'(1);

  state_t                   state_r;
  state_t                   state_next_s;
  logic [1:0]               rst_sync_r;
  logic                     run_s;
  logic [DataWidth-1:0]     mem_r [FifoDepth];
  logic [FifoAddrWidth-1:0] wr_ptr_r;
  logic [FifoAddrWidth-1:0] rd_ptr_r;
  logic [FifoAddrWidth:0]   count_r;
  logic [DataWidth-1:0]     head_s;
  logic                     head_host_s;
  logic                     fifo_empty_s;
  logic                     fifo_full_s;
  logic                     well_formed_s;
  logic                     pop_s;
  logic                     push_s;
  logic                     drop_ovf_s;
  logic                     drop_mal_s;
  logic [DataWidth-1:0]     net_data_r;
  logic [DataWidth-1:0]     host_data_r;
  logic                     net_valid_r;
  logic                     host_valid_r;
  logic                     overflow_r;
  logic                     malformed_r;

  // Reset release synchroniser; the datapath stays frozen until it settles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign run_s         = rst_sync_r[1];
  assign head_s        = mem_r[rd_ptr_r];
  assign head_host_s   = (head_s[39:37] == head_s[42:40]);
  assign fifo_empty_s  = (count_r == '0);
  assign fifo_full_s   = (count_r == DEPTH_C);
  assign well_formed_s = in_packet[63] & in_packet[62];

  // Next-state and pop decision; a pop always loads the head into the output register.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    if (run_s) begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            pop_s = 1'b1;
          end else begin
            pop_s = 1'b0;
          end
        end
        SEND_NET: begin
          if (net_ready) begin
            if (!fifo_empty_s) begin
              pop_s = 1'b1;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            pop_s = 1'b0;
          end
        end
        SEND_HOST: begin
          if (host_ready) begin
            if (!fifo_empty_s) begin
              pop_s = 1'b1;
            end else begin
              state_next_s = IDLE;
            end
          end else begin
            pop_s = 1'b0;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
      if (pop_s) begin
        state_next_s = head_host_s ? SEND_HOST : SEND_NET;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // A full FIFO still accepts a push when the same edge frees a slot.
  always_comb begin
    push_s     = 1'b0;
    drop_ovf_s = 1'b0;
    drop_mal_s = 1'b0;
    if (run_s && done) begin
      if (!well_formed_s) begin
        drop_mal_s = 1'b1;
      end else if (!fifo_full_s || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_ovf_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_packet;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state and output registers; data only changes when a new packet is popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      net_data_r   <= '0;
      host_data_r  <= '0;
      net_valid_r  <= 1'b0;
      host_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      net_valid_r  <= (state_next_s == SEND_NET);
      host_valid_r <= (state_next_s == SEND_HOST);
      if (pop_s) begin
        if (head_host_s) begin
          host_data_r <= head_s;
        end else begin
          net_data_r <= head_s;
        end
      end
    end
  end

  // Sticky drop flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r  <= 1'b0;
      malformed_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | drop_ovf_s;
      malformed_r <= malformed_r | drop_mal_s;
    end
  end

`ifdef REDUCE_EGRESS_STATS_EN
  logic [15:0] net_sent_cnt_r;
  logic [15:0] host_sent_cnt_r;
  logic [7:0]  drop_cnt_r;

  // Delivery counters wrap; the drop counter saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      net_sent_cnt_r  <= 16'd0;
      host_sent_cnt_r <= 16'd0;
      drop_cnt_r      <= 8'd0;
    end else begin
      if (net_valid_r && net_ready) begin
        net_sent_cnt_r <= net_sent_cnt_r + 16'd1;
      end
      if (host_valid_r && host_ready) begin
        host_sent_cnt_r <= host_sent_cnt_r + 16'd1;
      end
      if ((drop_ovf_s || drop_mal_s) && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  assign net_sent_cnt  = net_sent_cnt_r;
  assign host_sent_cnt = host_sent_cnt_r;
  assign drop_cnt      = drop_cnt_r;
`endif

  assign net_data   = net_data_r;
  assign net_valid  = net_valid_r;
  assign host_data  = host_data_r;
  assign host_valid = host_valid_r;
  assign overflow   = overflow_r;
  assign malformed  = malformed_r;
  assign fifo_count = count_r;

endmodule
